fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 15 +
 rtl/if_id_reg.sv | 50 +++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } fetch_state_e;

    localparam int INSTR_BYTES  = 4;
    localparam int OPCODE_WIDTH = 7;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load and clear
module if_id_reg #(
    parameter int PC_WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                clear,
    input  logic [31:0]         instr_in,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic                valid,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc
);

    logic                valid_q, valid_d;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    // Clear wins over load so a redirect always kills the incoming word.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch FSM feeding the decode stage
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                     PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect_valid,
    input  logic [PC_WIDTH-1:0]     redirect_pc,
    input  logic                    id_ready,
    output logic                    id_valid,
    output logic [31:0]             id_instr,
    output logic [PC_WIDTH-1:0]     id_pc,
    output logic [OPCODE_WIDTH-1:0] id_opcode
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                req_q, req_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic                id_load, id_clear;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = 1'b0;
        addr_d   = addr_q;
        id_load  = 1'b0;
        id_clear = 1'b0;

        if (redirect_valid) begin
            pc_d     = redirect_pc & ~PC_WIDTH'(3);
            id_clear = 1'b1;
            unique case (state_q)
                ST_FETCH: state_d = ST_DRAIN;
                ST_WAIT:  state_d = imem_rvalid ? ST_FETCH : ST_DRAIN;
                ST_DRAIN: state_d = ST_DRAIN;
                default:  state_d = ST_FETCH;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_FETCH;
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        id_load = 1'b1;
                        pc_d    = pc_q + PC_WIDTH'(INSTR_BYTES);
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (id_ready) begin
                        id_clear = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) state_d = ST_FETCH;
                end
                default:  state_d = ST_IDLE;
            endcase
        end

        // The request is registered, so it is raised on entry to FETCH.
        if (state_d == ST_FETCH) begin
            req_d  = 1'b1;
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    if_id_reg #(
        .PC_WIDTH(PC_WIDTH)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (id_load),
        .clear    (id_clear),
        .instr_in (imem_rdata),
        .pc_in    (pc_q),
        .valid    (id_valid),
        .instr    (id_instr),
        .pc       (id_pc)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_opcode = id_instr[OPCODE_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic [6:0]  id_opcode;

    int total = 0;
    int bad   = 0;
    int mem_lat;

    logic        mem_pend;
    int          mem_cnt;
    logic [63:0] mem_addr;

    fetch_unit #(.PC_WIDTH(64), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h00500093 ^ {a[23:0], 8'h00};
    endfunction

    // Memory answers each request mem_lat cycles after the request cycle.
    always @(posedge clk) begin
        if (rst) begin
            mem_pend    <= 1'b0;
            imem_rvalid <= 1'b0;
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_req) begin
                if (mem_lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(imem_addr);
                end else begin
                    mem_pend <= 1'b1;
                    mem_cnt  <= mem_lat - 1;
                    mem_addr <= imem_addr;
                end
            end else if (mem_pend) begin
                if (mem_cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(mem_addr);
                    mem_pend    <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        id_ready = 1'b0;
        mem_lat = 1;
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h200;
        repeat (3) @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 64'h0 || id_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: req=%b addr=%h valid=%b want 0 0 0", imem_req, imem_addr, id_valid);
        end
        total++;
        if (id_instr !== 32'h0 || id_pc !== 64'h0 || id_opcode !== 7'h0) begin
            bad++;
            $display("FAIL reset_data: instr=%h pc=%h op=%h want 0 0 0", id_instr, id_pc, id_opcode);
        end
        redirect_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            bad++;
            $display("FAIL reset_first_fetch: req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        int          req_k[$];
        logic [63:0] req_a[$];
        int          val_k[$];
        logic [63:0] val_pc[$];
        logic [31:0] val_in[$];
        id_ready = 1'b1;
        mem_lat = 1;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (imem_req) begin req_k.push_back(k); req_a.push_back(imem_addr); end
            if (id_valid) begin val_k.push_back(k); val_pc.push_back(id_pc); val_in.push_back(id_instr); end
        end
        total++;
        if (req_k.size() != 3 || val_k.size() != 3) begin
            bad++;
            $display("FAIL seq_counts: reqs=%0d valids=%0d want 3 3", req_k.size(), val_k.size());
        end
        for (int i = 0; i < 3 && i < req_k.size(); i++) begin
            total++;
            if (req_k[i] != 3 * i + 1 || req_a[i] !== 64'(4 * i)) begin
                bad++;
                $display("FAIL seq_req%0d: cyc=%0d addr=%h want %0d %h", i, req_k[i], req_a[i], 3 * i + 1, 4 * i);
            end
        end
        for (int i = 0; i < 3 && i < val_k.size(); i++) begin
            total++;
            if (val_k[i] != 3 * i + 3 || val_pc[i] !== 64'(4 * i) || val_in[i] !== mem_word(64'(4 * i))) begin
                bad++;
                $display("FAIL seq_id%0d: cyc=%0d pc=%h instr=%h want %0d %h %h", i, val_k[i], val_pc[i],
                         val_in[i], 3 * i + 3, 4 * i, mem_word(64'(4 * i)));
            end
        end
    endtask

    task automatic test_hold();
        id_ready = 1'b0;
        mem_lat = 1;
        do_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (id_valid !== 1'b1 || id_instr !== 32'h00500093 || id_opcode !== 7'h13 || id_pc !== 64'h0 || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable%0d: valid=%b instr=%h op=%h pc=%h req=%b want 1 00500093 13 0 0",
                         i, id_valid, id_instr, id_opcode, id_pc, imem_req);
            end
            @(negedge clk);
        end
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        total++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h4) begin
            bad++;
            $display("FAIL hold_release: valid=%b req=%b addr=%h want 0 1 4", id_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_hold();
        id_ready = 1'b0;
        mem_lat = 1;
        do_reset();
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 64'h82;
        id_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        total++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h80) begin
            bad++;
            $display("FAIL redir_hold: valid=%b req=%b addr=%h want 0 1 80", id_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        id_ready = 1'b1;
        mem_lat = 4;
        do_reset();
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 64'h103;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            total++;
            if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL drain_cyc%0d: valid=%b req=%b want 0 0", k, id_valid, imem_req);
            end
            @(negedge clk);
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin
            bad++;
            $display("FAIL drain_refetch: req=%b addr=%h want 1 100", imem_req, imem_addr);
        end
        for (int k = 7; k <= 10; k++) begin
            @(negedge clk);
            total++;
            if (id_valid !== 1'b0) begin
                bad++;
                $display("FAIL drain_wait_cyc%0d: valid=%b pc=%h want valid 0", k, id_valid, id_pc);
            end
        end
        @(negedge clk);
        total++;
        if (id_valid !== 1'b1 || id_pc !== 64'h100 || id_instr !== mem_word(64'h100)) begin
            bad++;
            $display("FAIL drain_deliver: valid=%b pc=%h instr=%h want 1 100 %h", id_valid, id_pc, id_instr, mem_word(64'h100));
        end
    endtask

    task automatic test_redirect_coincident();
        id_ready = 1'b1;
        mem_lat = 1;
        do_reset();
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h40) begin
            bad++;
            $display("FAIL coinc_refetch: valid=%b req=%b addr=%h want 0 1 40", id_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        total++;
        if (id_valid !== 1'b0) begin
            bad++;
            $display("FAIL coinc_wait: valid=%b want 0", id_valid);
        end
        @(negedge clk);
        total++;
        if (id_valid !== 1'b1 || id_pc !== 64'h40 || id_instr !== mem_word(64'h40)) begin
            bad++;
            $display("FAIL coinc_deliver: valid=%b pc=%h instr=%h want 1 40 %h", id_valid, id_pc, id_instr, mem_word(64'h40));
        end
    endtask

    task automatic test_wrap();
        id_ready = 1'b1;
        mem_lat = 1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_idle_redir: req=%b addr=%h want 1 fffffffffffffffc", imem_req, imem_addr);
        end
        repeat (2) @(negedge clk);
        total++;
        if (id_valid !== 1'b1 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_id: valid=%b pc=%h want 1 fffffffffffffffc", id_valid, id_pc);
        end
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            bad++;
            $display("FAIL wrap_next: req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_in_hold();
        id_ready = 1'b0;
        mem_lat = 1;
        do_reset();
        repeat (3) @(negedge clk);
        total++;
        if (id_valid !== 1'b1) begin
            bad++;
            $display("FAIL rsthold_pre: valid=%b want 1", id_valid);
        end
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h200;
        @(negedge clk);
        total++;
        if (id_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 64'h0 || id_pc !== 64'h0 || id_instr !== 32'h0) begin
            bad++;
            $display("FAIL rsthold_clear: valid=%b req=%b addr=%h pc=%h instr=%h want 0 0 0 0 0",
                     id_valid, imem_req, imem_addr, id_pc, id_instr);
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            bad++;
            $display("FAIL rsthold_refetch: req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        mem_lat = 1;
        imem_rdata = '0;
        test_reset();
        test_sequential();
        test_hold();
        test_redirect_hold();
        test_redirect_wait();
        test_redirect_coincident();
        test_wrap();
        test_reset_in_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
